// File: rtl/cau_bridge_pkg.sv
// Register indices and CTRL/STATUS bit positions shared by the APB stream FIFO bridge.
package cau_bridge_pkg;

    localparam logic [3:0] REG_CTRL     = 4'h1;
    localparam logic [3:0] REG_STATUS   = 4'h2;
    localparam logic [3:0] REG_RX_DATA  = 4'h3;
    localparam logic [3:0] REG_TX_DATA  = 4'h5;
    localparam logic [3:0] REG_TX_COUNT = 4'h6;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_RX_EN      = 1;
    localparam int CTRL_TX_FLUSH   = 2;
    localparam int CTRL_RX_FLUSH   = 3;
    localparam int CTRL_IRQ_EN     = 4;
    localparam int CTRL_THRESH_LSB = 8;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_RX_NONEMPTY  = 1;
    localparam int ST_TX_EMPTY     = 2;
    localparam int ST_RX_FULL      = 3;
    localparam int ST_RX_OVF       = 4;
    localparam int ST_TX_OVF       = 5;
    localparam int ST_RX_UDF       = 6;
    localparam int ST_RX_COUNT_LSB = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with flush; a push while full succeeds
// when a pop happens on the same edge, and flush discards any same-edge push.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = CNT_W - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok) & ~flush;

    always_ff @(posedge pclk) begin
        if (!prstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge pclk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/apb_stream_fifo_bridge.sv
// APB2 slave buffering words between the soft core and a streaming engine through
// independent TX and RX FIFOs, with status, level counts and an RX-threshold interrupt.
module apb_stream_fifo_bridge
    import cau_bridge_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          DEPTH      = 256,
    parameter int          CNT_W      = $clog2(DEPTH) + 1,
    parameter logic [7:0]  THRESH_RST = 8'd16
) (
    input  logic              apb_pclk,
    input  logic              apb_prstn,
    input  logic              apb_psel,
    input  logic              apb_penable,
    input  logic              apb_pwrite,
    input  logic [31:0]       apb_paddr,
    input  logic [31:0]       apb_pwdata,
    output logic [31:0]       apb_prdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              irq
);

    logic [3:0]        addr;
    logic              paddr_unused;
    logic              wr_acc, rd_setup, rd_acc;
    logic              ctrl_wr, status_wr, rx_rd;
    logic              tx_en, rx_en, irq_en;
    logic [7:0]        rx_thresh;
    logic              rx_ovf, tx_ovf, rx_udf, rd_pop_ok;
    logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic [DATA_W-1:0] rx_head;
    logic              tx_ovf_set, rx_ovf_set, rx_udf_set;
    logic [2:0]        w1c;
    logic [31:0]       rd_mux;

    assign addr         = apb_paddr[3:0];
    assign paddr_unused = ^apb_paddr[31:4];

    assign wr_acc   = apb_psel &  apb_penable &  apb_pwrite;
    assign rd_setup = apb_psel & ~apb_penable & ~apb_pwrite;
    assign rd_acc   = apb_psel &  apb_penable & ~apb_pwrite;

    assign ctrl_wr   = wr_acc & (addr == REG_CTRL);
    assign status_wr = wr_acc & (addr == REG_STATUS);
    assign rx_rd     = rd_acc & (addr == REG_RX_DATA);

    assign tx_valid = tx_en & ~tx_empty;
    assign rx_ready = rx_en & ~rx_full;

    assign tx_push  = wr_acc & (addr == REG_TX_DATA);
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_flush = ctrl_wr & apb_pwdata[CTRL_TX_FLUSH];
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rx_rd & rd_pop_ok;
    assign rx_flush = ctrl_wr & apb_pwdata[CTRL_RX_FLUSH];

    // A pop on the same edge makes room, so a write to a full TX FIFO is not an overflow.
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop & ~tx_flush;
    assign rx_ovf_set = rx_valid & rx_full & ~rx_flush;
    assign rx_udf_set = rx_rd & ~rd_pop_ok;
    assign w1c        = status_wr ? apb_pwdata[ST_RX_UDF:ST_RX_OVF] : 3'b000;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
        .pclk      (apb_pclk),
        .prstn     (apb_prstn),
        .flush     (tx_flush),
        .push      (tx_push),
        .push_data (apb_pwdata[DATA_W-1:0]),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
        .pclk      (apb_pclk),
        .prstn     (apb_prstn),
        .flush     (rx_flush),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_comb begin
        rd_mux = '0;
        case (addr)
            REG_CTRL: begin
                rd_mux[CTRL_TX_EN]                = tx_en;
                rd_mux[CTRL_RX_EN]                = rx_en;
                rd_mux[CTRL_IRQ_EN]               = irq_en;
                rd_mux[CTRL_THRESH_LSB +: 8]      = rx_thresh;
            end
            REG_STATUS: begin
                rd_mux[ST_TX_FULL]                = tx_full;
                rd_mux[ST_RX_NONEMPTY]            = ~rx_empty;
                rd_mux[ST_TX_EMPTY]               = tx_empty;
                rd_mux[ST_RX_FULL]                = rx_full;
                rd_mux[ST_RX_OVF]                 = rx_ovf;
                rd_mux[ST_TX_OVF]                 = tx_ovf;
                rd_mux[ST_RX_UDF]                 = rx_udf;
                rd_mux[ST_RX_COUNT_LSB +: 16]     = 16'(rx_count);
            end
            REG_RX_DATA:  rd_mux = rx_empty ? 32'd0 : 32'(rx_head);
            REG_TX_COUNT: rd_mux = 32'(tx_count);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) begin
            tx_en      <= 1'b0;
            rx_en      <= 1'b0;
            irq_en     <= 1'b0;
            rx_thresh  <= THRESH_RST;
            rx_ovf     <= 1'b0;
            tx_ovf     <= 1'b0;
            rx_udf     <= 1'b0;
            rd_pop_ok  <= 1'b0;
            apb_prdata <= '0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                tx_en     <= apb_pwdata[CTRL_TX_EN];
                rx_en     <= apb_pwdata[CTRL_RX_EN];
                irq_en    <= apb_pwdata[CTRL_IRQ_EN];
                rx_thresh <= apb_pwdata[CTRL_THRESH_LSB +: 8];
            end
            // A new event on the same edge as its W1C keeps the flag set.
            rx_ovf <= rx_ovf_set | (rx_ovf & ~w1c[0]);
            tx_ovf <= tx_ovf_set | (tx_ovf & ~w1c[1]);
            rx_udf <= rx_udf_set | (rx_udf & ~w1c[2]);
            // The pop decision is taken with the data captured at setup so no unseen word is lost.
            if (rd_setup) begin
                apb_prdata <= rd_mux;
                rd_pop_ok  <= (addr == REG_RX_DATA) & ~rx_empty;
            end
            irq <= irq_en & ((32'(rx_count) >= 32'(rx_thresh)) | rx_ovf | tx_ovf);
        end
    end

endmodule

// File: tb/tb_apb_stream_fifo_bridge.sv
// Bench for apb_stream_fifo_bridge: queue-based reference model checked every cycle,
// a register vector table, directed corner sequences and a randomized phase.
module tb_apb_stream_fifo_bridge;

    localparam int DEPTH = 256;

    typedef struct {
        bit          wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    logic        pclk = 1'b0;
    logic        prstn, psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata, tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

    always #5 pclk = ~pclk;

    apb_stream_fifo_bridge #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .apb_pclk    (pclk),
        .apb_prstn   (prstn),
        .apb_psel    (psel),
        .apb_penable (penable),
        .apb_pwrite  (pwrite),
        .apb_paddr   (paddr),
        .apb_pwdata  (pwdata),
        .apb_prdata  (prdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .irq         (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          drv_rstn = 1'b0, drv_rxv = 1'b0, drv_txr = 1'b0, chk_en = 1'b0;
    logic [31:0] drv_rxd = '0;
    logic [31:0] smp_prdata;
    logic        smp_irq, smp_rxr;
    logic [31:0] tx_seen[$];

    // Reference model state
    logic [31:0] m_txq[$], m_rxq[$];
    bit          m_tx_en, m_rx_en, m_irq_en, m_rx_ovf, m_tx_ovf, m_rx_udf, m_irq, m_rd_ok;
    logic [7:0]  m_thresh;
    logic [31:0] m_prdata;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_txq.delete();
        m_rxq.delete();
        m_tx_en = 0; m_rx_en = 0; m_irq_en = 0;
        m_rx_ovf = 0; m_tx_ovf = 0; m_rx_udf = 0;
        m_irq = 0; m_rd_ok = 0;
        m_thresh = 8'd16;
        m_prdata = '0;
    endfunction

    function automatic logic [31:0] m_reg(logic [3:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            4'h1: v = {16'd0, m_thresh, 3'b000, m_irq_en, 2'b00, m_rx_en, m_tx_en};
            4'h2: v = {16'(m_rxq.size()), 9'd0, m_rx_udf, m_tx_ovf, m_rx_ovf,
                       m_rxq.size() == DEPTH, m_txq.size() == 0,
                       m_rxq.size() != 0, m_txq.size() == DEPTH};
            4'h3: v = (m_rxq.size() != 0) ? m_rxq[0] : 32'd0;
            4'h6: v = 32'(m_txq.size());
            default: v = '0;
        endcase
        return v;
    endfunction

    // One clock: drive at negedge, compare outputs with the model, then advance the model.
    task automatic cycle(bit s, bit en, bit w, logic [3:0] a, logic [31:0] d);
        bit          wr, su, acc, txv, rxr, popped, txfl, rxfl, tx_full0, rx_full0;
        bit          set_txo, set_rxo, set_udf, irq_n, rdok_n;
        logic [31:0] clr, prd_n;
        @(negedge pclk);
        prstn    = drv_rstn;
        psel     = s;
        penable  = en;
        pwrite   = w;
        paddr    = ($urandom() & 32'hFFFF_FFF0) | {28'd0, a};
        pwdata   = d;
        rx_valid = drv_rxv;
        rx_data  = drv_rxd;
        tx_ready = drv_txr;
        #1;
        smp_prdata = prdata;
        smp_irq    = irq;
        smp_rxr    = rx_ready;
        if (chk_en) begin
            check("tx_valid", {31'd0, tx_valid}, {31'd0, m_tx_en && m_txq.size() != 0});
            if (m_txq.size() != 0) check("tx_data", tx_data, m_txq[0]);
            check("rx_ready", {31'd0, rx_ready}, {31'd0, m_rx_en && m_rxq.size() < DEPTH});
            check("irq", {31'd0, irq}, {31'd0, m_irq});
            check("prdata", prdata, m_prdata);
        end
        if (tx_valid === 1'b1 && drv_txr) tx_seen.push_back(tx_data);
        @(posedge pclk);
        if (!drv_rstn) begin
            m_reset();
        end else begin
            wr  = s & en & w;
            su  = s & !en & !w;
            acc = s & en & !w;
            txv = m_tx_en && m_txq.size() != 0;
            rxr = m_rx_en && m_rxq.size() < DEPTH;
            tx_full0 = (m_txq.size() == DEPTH);
            rx_full0 = (m_rxq.size() == DEPTH);
            irq_n  = m_irq_en && (m_rxq.size() >= int'(m_thresh) || m_rx_ovf || m_tx_ovf);
            prd_n  = su ? m_reg(a) : m_prdata;
            rdok_n = su ? (a == 4'h3 && m_rxq.size() != 0) : m_rd_ok;
            txfl   = wr && a == 4'h1 && d[2];
            rxfl   = wr && a == 4'h1 && d[3];
            clr    = (wr && a == 4'h2) ? d : 32'd0;
            popped = 0; set_txo = 0; set_rxo = 0; set_udf = 0;
            if (txv && drv_txr) begin
                void'(m_txq.pop_front());
                popped = 1;
            end
            if (wr && a == 4'h5) begin
                if (!tx_full0 || popped) m_txq.push_back(d);
                else set_txo = 1;
            end
            if (acc && a == 4'h3) begin
                if (m_rd_ok) void'(m_rxq.pop_front());
                else set_udf = 1;
            end
            if (drv_rxv && !rxfl) begin
                if (rxr) m_rxq.push_back(drv_rxd);
                else if (rx_full0) set_rxo = 1;
            end
            if (txfl) m_txq.delete();
            if (rxfl) m_rxq.delete();
            m_rx_ovf = (m_rx_ovf && !clr[4]) || set_rxo;
            m_tx_ovf = (m_tx_ovf && !clr[5]) || set_txo;
            m_rx_udf = (m_rx_udf && !clr[6]) || set_udf;
            if (wr && a == 4'h1) begin
                m_tx_en  = d[0];
                m_rx_en  = d[1];
                m_irq_en = d[4];
                m_thresh = d[15:8];
            end
            m_irq    = irq_n;
            m_prdata = prd_n;
            m_rd_ok  = rdok_n;
        end
    endtask

    task automatic idle(int n);
        repeat (n) cycle(0, 0, 0, 4'h0, 32'd0);
    endtask

    task automatic apb_write(logic [3:0] a, logic [31:0] d);
        cycle(1, 0, 1, a, d);
        cycle(1, 1, 1, a, d);
    endtask

    task automatic apb_read(logic [3:0] a, output logic [31:0] r);
        cycle(1, 0, 0, a, $urandom());
        cycle(1, 1, 0, a, $urandom());
        r = smp_prdata;
    endtask

    task automatic do_reset();
        drv_rstn = 0; drv_rxv = 0; drv_txr = 0;
        idle(1);
        chk_en = 1;
        idle(1);
        drv_rstn = 1;
        idle(1);
    endtask

    vec_t        tab[$];
    logic [31:0] r, d;

    initial begin
        prstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        rx_valid = 0; rx_data = '0; tx_ready = 0;
        m_reset();
        do_reset();

        // Reset state
        check("rst_irq", {31'd0, smp_irq}, 32'd0);
        check("rst_rx_ready", {31'd0, smp_rxr}, 32'd0);

        // Register vector table
        tab.push_back('{0, 4'h2, 32'h0, 32'h0000_0004});
        tab.push_back('{0, 4'h1, 32'h0, 32'h0000_1000});
        tab.push_back('{0, 4'h6, 32'h0, 32'h0000_0000});
        tab.push_back('{0, 4'h0, 32'h0, 32'h0000_0000});
        tab.push_back('{0, 4'h7, 32'h0, 32'h0000_0000});
        tab.push_back('{0, 4'hF, 32'h0, 32'h0000_0000});
        tab.push_back('{0, 4'h3, 32'h0, 32'h0000_0000});
        tab.push_back('{0, 4'h2, 32'h0, 32'h0000_0044});
        tab.push_back('{1, 4'h2, 32'h0000_0040, 32'h0});
        tab.push_back('{0, 4'h2, 32'h0, 32'h0000_0004});
        tab.push_back('{1, 4'h1, 32'hFFFF_AB1F, 32'h0});
        tab.push_back('{0, 4'h1, 32'h0, 32'h0000_AB13});
        tab.push_back('{1, 4'h1, 32'h0000_0000, 32'h0});
        tab.push_back('{0, 4'h1, 32'h0, 32'h0000_0000});
        tab.push_back('{1, 4'h0, 32'hFFFF_FFFF, 32'h0});
        tab.push_back('{0, 4'h0, 32'h0, 32'h0000_0000});
        tab.push_back('{1, 4'h6, 32'h0000_0055, 32'h0});
        tab.push_back('{0, 4'h6, 32'h0, 32'h0000_0000});
        tab.push_back('{1, 4'h3, 32'h0000_0077, 32'h0});
        tab.push_back('{0, 4'h2, 32'h0, 32'h0000_0004});
        tab.push_back('{1, 4'h5, 32'h0000_1234, 32'h0});
        tab.push_back('{0, 4'h6, 32'h0, 32'h0000_0001});
        tab.push_back('{0, 4'h2, 32'h0, 32'h0000_0000});
        tab.push_back('{1, 4'h1, 32'h0000_0004, 32'h0});
        tab.push_back('{0, 4'h6, 32'h0, 32'h0000_0000});
        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].wr) apb_write(tab[i].a, tab[i].d);
            else begin
                apb_read(tab[i].a, r);
                check($sformatf("table[%0d]", i), r, tab[i].exp);
            end
        end

        // Threshold 0 raises irq as soon as irq_en is set
        apb_write(4'h1, 32'h0000_0010);
        idle(2);
        check("irq_thresh0", {31'd0, smp_irq}, 32'd1);
        apb_write(4'h1, 32'h0);

        // TX fill, overflow, then drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) apb_write(4'h5, i);
        apb_write(4'h5, 32'h0000_0999);
        apb_read(4'h6, r);
        check("tx_count_full", r, 32'd256);
        apb_read(4'h2, r);
        check("status_tx_full_ovf", r, 32'h0000_0021);
        tx_seen.delete();
        drv_txr = 1;
        apb_write(4'h1, 32'h1);
        idle(DEPTH + 2);
        drv_txr = 0;
        check("tx_drain_len", tx_seen.size(), 32'd256);
        for (int i = 0; i < DEPTH; i++)
            check("tx_order", (i < tx_seen.size()) ? tx_seen[i] : 32'hDEAD_DEAD, i);
        apb_write(4'h2, 32'h20);
        apb_read(4'h2, r);
        check("tx_ovf_w1c", r, 32'h0000_0004);

        // RX threshold interrupt
        do_reset();
        apb_write(4'h1, 32'h0812);
        for (int i = 0; i < 8; i++) begin
            drv_rxv = 1;
            drv_rxd = 32'hA0 + i;
            idle(1);
        end
        drv_rxv = 0;
        idle(1);
        check("irq_before", {31'd0, smp_irq}, 32'd0);
        idle(1);
        check("irq_rise", {31'd0, smp_irq}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            apb_read(4'h3, r);
            check("rx_read", r, 32'hA0 + i);
        end
        idle(2);
        check("irq_fall", {31'd0, smp_irq}, 32'd0);

        // RX full and overflow
        do_reset();
        apb_write(4'h1, 32'h0812);
        drv_rxv = 1;
        for (int i = 0; i < DEPTH; i++) begin
            drv_rxd = i;
            idle(1);
        end
        drv_rxd = 32'hDEAD;
        idle(1);
        check("rx_ready_full", {31'd0, smp_rxr}, 32'd0);
        drv_rxv = 0;
        idle(1);
        apb_read(4'h2, r);
        check("status_rx_ovf", r, 32'h0100_001E);
        check("irq_rx_full", {31'd0, smp_irq}, 32'd1);
        apb_write(4'h2, 32'h10);
        apb_read(4'h2, r);
        check("rx_ovf_w1c", r, 32'h0100_000E);
        apb_read(4'h3, r);
        check("rx_head_after_full", r, 32'd0);
        apb_write(4'h1, 32'h0808);
        apb_read(4'h2, r);
        check("rx_flush", r, 32'h0000_0004);

        // Underflow read
        apb_read(4'h3, r);
        check("rx_udf_data", r, 32'd0);
        apb_read(4'h2, r);
        check("rx_udf_status", r, 32'h0000_0044);

        // TX full with a pop on the push edge
        do_reset();
        apb_write(4'h1, 32'h1);
        for (int i = 0; i < DEPTH; i++) apb_write(4'h5, 32'h100 + i);
        cycle(1, 0, 1, 4'h5, 32'hBEEF);
        drv_txr = 1;
        cycle(1, 1, 1, 4'h5, 32'hBEEF);
        drv_txr = 0;
        apb_read(4'h6, r);
        check("tx_full_push_pop", r, 32'd256);
        apb_read(4'h2, r);
        check("tx_full_no_ovf", r, 32'h0000_0001);
        apb_write(4'h1, 32'h5);
        apb_read(4'h6, r);
        check("tx_flush", r, 32'd0);

        // RX flush on the same edge as a stream push
        apb_write(4'h1, 32'h2);
        drv_rxv = 1;
        idle(3);
        drv_rxv = 0;
        cycle(1, 0, 1, 4'h1, 32'hA);
        drv_rxv = 1;
        cycle(1, 1, 1, 4'h1, 32'hA);
        drv_rxv = 0;
        apb_read(4'h2, r);
        check("rx_flush_push", r, 32'h0000_0004);

        // Reset in the middle of a transfer
        apb_write(4'h1, 32'h0);
        for (int i = 0; i < 3; i++) apb_write(4'h5, i);
        cycle(1, 0, 1, 4'h5, 32'h77);
        drv_rstn = 0;
        cycle(1, 1, 1, 4'h5, 32'h77);
        drv_rstn = 1;
        idle(1);
        apb_read(4'h6, r);
        check("midreset_tx_count", r, 32'd0);
        apb_read(4'h1, r);
        check("midreset_ctrl", r, 32'h0000_1000);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 700; k++) begin
            drv_rxv = ($urandom_range(0, 2) != 0);
            drv_rxd = $urandom();
            drv_txr = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: apb_write(4'h5, $urandom());
                3, 4:    apb_read(4'($urandom_range(0, 7)), r);
                5:       apb_read(4'h3, r);
                6: begin
                    d = $urandom();
                    if ($urandom_range(0, 7) != 0) d[3:2] = 2'b00;
                    d[15:8] = 8'($urandom_range(0, 40));
                    apb_write(4'h1, d);
                end
                7:       apb_write(4'h2, $urandom());
                8:       idle($urandom_range(1, 3));
                default: apb_write(4'($urandom_range(0, 15)), $urandom());
            endcase
        end
        drv_rxv = 0;
        drv_txr = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
